// File: rtl/shifter_lut_arbiter.sv
// Round-robin arbiter sharing one registered shifter LUT among several lanes.
// Issues at most one lookup per cycle; returns the LUT result tagged with the lane id.
module shifter_lut_arbiter #(
    parameter int unsigned kNumRequesters  = 4,
    parameter int unsigned kAngleLength    = 8,
    parameter int unsigned kAccuBaseLength = 16,
    parameter int unsigned kIdLength       = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [kNumRequesters-1:0]              req,
    input  logic [kNumRequesters*kAngleLength-1:0] req_angle,
    output logic [kNumRequesters-1:0]              grant,
    output logic [kAngleLength-1:0]                lut_angle,
    input  logic [kAccuBaseLength-1:0]             lut_accu_base,
    output logic                                   rsp_valid,
    output logic [kIdLength-1:0]                   rsp_id,
    output logic [kAccuBaseLength-1:0]             rsp_accu_base,
    output logic                                   rsp_error,
    output logic                                   busy
);

    localparam logic [kAngleLength-1:0] kAngleLimit = kAngleLength'(180);
    localparam logic [kIdLength-1:0]    kLastInit   = kIdLength'(kNumRequesters - 1);

    logic [kNumRequesters-1:0] grant_q, grant_d;
    logic [kAngleLength-1:0]   lut_angle_q, lut_angle_d;
    logic [kIdLength-1:0]      last_q, last_d;
    logic                      s1_valid_q, s1_valid_d;
    logic [kIdLength-1:0]      s1_id_q, s1_id_d;
    logic                      s1_err_q, s1_err_d;
    logic                      rsp_valid_q;
    logic [kIdLength-1:0]      rsp_id_q;
    logic                      rsp_err_q;

    logic [kNumRequesters-1:0] elig;
    logic                      found;
    logic [kIdLength-1:0]      win;
    logic [kAngleLength-1:0]   win_angle;
    int unsigned               start;

    // The lane holding grant this cycle is masked so a held req is not granted twice.
    assign elig = req & ~grant_q;

    always_comb begin
        found     = 1'b0;
        win       = '0;
        win_angle = '0;
        start     = 32'(last_q);
        for (int unsigned i = 1; i <= kNumRequesters; i++) begin
            for (int unsigned j = 0; j < kNumRequesters; j++) begin
                if (!found && elig[j] && (j == (start + i) % kNumRequesters)) begin
                    found     = 1'b1;
                    win       = kIdLength'(j);
                    win_angle = req_angle[j*kAngleLength +: kAngleLength];
                end
            end
        end
    end

    always_comb begin
        grant_d     = '0;
        lut_angle_d = lut_angle_q;
        last_d      = last_q;
        s1_valid_d  = 1'b0;
        s1_id_d     = s1_id_q;
        s1_err_d    = s1_err_q;
        if (found) begin
            for (int unsigned j = 0; j < kNumRequesters; j++) begin
                grant_d[j] = (win == kIdLength'(j));
            end
            lut_angle_d = win_angle;
            last_d      = win;
            s1_valid_d  = 1'b1;
            s1_id_d     = win;
            s1_err_d    = (win_angle >= kAngleLimit);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q     <= '0;
            lut_angle_q <= '0;
            last_q      <= kLastInit;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            s1_err_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            grant_q     <= grant_d;
            lut_angle_q <= lut_angle_d;
            last_q      <= last_d;
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            s1_err_q    <= s1_err_d;
            rsp_valid_q <= s1_valid_q;
            rsp_id_q    <= s1_id_q;
            rsp_err_q   <= s1_err_q;
        end
    end

    assign grant         = grant_q;
    assign lut_angle     = lut_angle_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_error     = rsp_err_q;
    // Out-of-range angles still look up the LUT; the result is masked here.
    assign rsp_accu_base = rsp_err_q ? '0 : lut_accu_base;
    assign busy          = s1_valid_q | rsp_valid_q;

endmodule
